// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute controller for the 8-bit CPU.
// Fetches 16-bit instructions, holds a 4-entry register file and the
// architectural flags, and sequences the downstream ALU.

package defs_pkg;

  // ALU operation select shared with the alu block.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_opcode_t;

  // ALU status flags.
  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage

module cpu_ctrl #(
  parameter int WIDTH = 8,
  parameter int PC_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_valid,
  input  logic [15:0]           imem_data,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [WIDTH-1:0]      alu_in2,
  output defs_pkg::alu_opcode_t alu_op,
  input  logic [WIDTH-1:0]      alu_out,
  input  defs_pkg::alu_flags_t  alu_flags,
  output defs_pkg::alu_flags_t  flags_q,
  output logic [PC_W-1:0]       pc,
  output logic                  retired,
  output logic                  halted,
  output logic                  illegal,
  input  logic [1:0]            dbg_sel,
  output logic [WIDTH-1:0]      dbg_rdata
);

  import defs_pkg::*;

  // Controller states.
  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  // Instruction opcodes (IR[15:12]); 0xB..0xE are illegal.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  // Opcodes in the reserved hole between ADDI and HALT.
  function automatic logic f_is_illegal(input logic [3:0] opc);
    logic res;
    case (opc)
      4'hB, 4'hC, 4'hD, 4'hE: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcodes whose result comes from the ALU and which update the flags.
  function automatic logic f_uses_alu(input logic [3:0] opc);
    logic res;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_ADDI: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

  // Single-bit shifts ignore rs and present zero on operand 2.
  function automatic logic f_is_shift(input logic [3:0] opc);
    logic res;
    case (opc)
      OP_SLL, OP_SRL, OP_SRA: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Instruction opcode to ALU operation.
  function automatic alu_opcode_t f_alu_sel(input logic [3:0] opc);
    alu_opcode_t res;
    case (opc)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      OP_SLL:  res = ALU_SLL;
      OP_SRL:  res = ALU_SRL;
      OP_SRA:  res = ALU_SRA;
      OP_ADDI: res = ALU_ADD;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Architectural and pipeline state.
  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic [15:0]      r_ir;
  logic [WIDTH-1:0] r_regs [4];
  alu_flags_t       r_flags;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  alu_opcode_t      r_alu_op;
  logic             r_retired;
  logic             r_halted;
  logic             r_illegal;

  // Decode of the held instruction.
  logic [1:0]       w_state_nxt;
  logic [3:0]       w_opc;
  logic [1:0]       w_rd;
  logic [1:0]       w_rs;
  logic [WIDTH-1:0] w_imm;
  logic             w_is_illegal;
  logic             w_uses_alu;
  logic             w_is_shift;
  logic             w_fetch_fire;
  logic             w_in_decode;
  logic             w_in_exec;
  logic             w_wb_en;
  logic [WIDTH-1:0] w_wb_data;
  logic [WIDTH-1:0] w_op2;

  assign w_opc        = r_ir[15:12];
  assign w_rd         = r_ir[11:10];
  assign w_rs         = r_ir[9:8];
  assign w_imm        = WIDTH'(r_ir[7:0]);
  assign w_is_illegal = f_is_illegal(w_opc);
  assign w_uses_alu   = f_uses_alu(w_opc);
  assign w_is_shift   = f_is_shift(w_opc);
  assign w_fetch_fire = (r_state == S_FETCH) && imem_valid;
  assign w_in_decode  = (r_state == S_DECODE);
  assign w_in_exec    = (r_state == S_EXEC);

  // Next-state selection for the fetch/decode/execute sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_valid) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_is_illegal || (w_opc == OP_HALT)) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC:  w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Operand 2 choice: zero for shifts, the immediate for ADDI, else R[rs].
  always_comb begin
    w_op2 = r_regs[w_rs];
    if (w_is_shift) begin
      w_op2 = '0;
    end else if (w_opc == OP_ADDI) begin
      w_op2 = w_imm;
    end else begin
      w_op2 = r_regs[w_rs];
    end
  end

  // Writeback source: ALU result for ALU ops/ADDI, immediate for LI.
  always_comb begin
    w_wb_en   = 1'b0;
    w_wb_data = alu_out;
    if (w_uses_alu) begin
      w_wb_en   = w_in_exec;
      w_wb_data = alu_out;
    end else if (w_opc == OP_LI) begin
      w_wb_en   = w_in_exec;
      w_wb_data = w_imm;
    end else begin
      w_wb_en   = 1'b0;
      w_wb_data = alu_out;
    end
  end

  // State, program counter and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch_fire) begin
        r_ir <= imem_data;
        r_pc <= r_pc + PC_ONE;
      end
    end
  end

  // Operand registers feed the ALU; they only move when an ALU op is decoded,
  // so the ALU inputs hold their last values outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_alu_op  <= ALU_ADD;
    end else begin
      if (w_in_decode && w_uses_alu) begin
        r_alu_in1 <= r_regs[w_rd];
        r_alu_in2 <= w_op2;
        r_alu_op  <= f_alu_sel(w_opc);
      end else begin
        r_alu_op  <= ALU_ADD;
      end
    end
  end

  // Register file and flags writeback at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
      r_flags <= '0;
    end else begin
      if (w_wb_en) begin
        r_regs[w_rd] <= w_wb_data;
      end
      if (w_in_exec && w_uses_alu) begin
        r_flags <= alu_flags;
      end
    end
  end

  // Status: retire pulse, halted and the sticky illegal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_retired <= w_in_exec || (w_in_decode && (w_opc == OP_HALT));
      r_halted  <= (w_state_nxt == S_HALT);
      if (w_in_decode && w_is_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // The request is masked by rst so it is low while reset is held yet
  // already high in the first cycle after release.
  assign imem_req  = (r_state == S_FETCH) && !rst;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign alu_in1   = r_alu_in1;
  assign alu_in2   = r_alu_in2;
  assign alu_op    = r_alu_op;
  assign flags_q   = r_flags;
  assign retired   = r_retired;
  assign halted    = r_halted;
  assign illegal   = r_illegal;
  assign dbg_rdata = r_regs[dbg_sel];

endmodule

// File: tb/tb_cpu_ctrl.sv
// Testbench for cpu_ctrl: an ALU stand-in, an instruction memory and an
// instruction-level reference model that predicts cycle timing and state.
module tb_cpu_ctrl;
  import defs_pkg::*;

  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  alu_opcode_t alu_op;
  alu_flags_t  alu_flags, flags_q;
  logic [7:0]  pc;
  logic        retired, halted, illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_rdata;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl #(.WIDTH(8), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out),
    .alu_flags(alu_flags), .flags_q(flags_q), .pc(pc), .retired(retired),
    .halted(halted), .illegal(illegal), .dbg_sel(dbg_sel),
    .dbg_rdata(dbg_rdata)
  );

  assign imem_data = mem[imem_addr];

  // Behavioural ALU: returns {carry, zero, neg, ovf, result}.
  function automatic logic [11:0] alu_fn(alu_opcode_t op, logic [7:0] a, logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                     v = (a[7] == b[7]) && (r[7] != a[7]); end
      ALU_SUB: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      ALU_SRL: begin r = {1'b0, a[7:1]}; c = a[0]; end
      ALU_SRA: begin r = {a[7], a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r[7], v, r};
  endfunction

  always_comb begin
    {alu_flags, alu_out} = alu_fn(alu_op, alu_in1, alu_in2);
  end

  function automatic alu_opcode_t op_to_alu(logic [3:0] o);
    case (o)
      4'h1: return ALU_ADD;
      4'h2: return ALU_SUB;
      4'h3: return ALU_AND;
      4'h4: return ALU_OR;
      4'h5: return ALU_XOR;
      4'h6: return ALU_SLL;
      4'h7: return ALU_SRL;
      4'h8: return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [15:0] ins(logic [3:0] o, logic [1:0] rd, logic [1:0] rs, logic [7:0] imm);
    return {o, rd, rs, imm};
  endfunction

  // Program under test and per-instruction fetch stall counts.
  logic [15:0] prog[$];
  int          stall_q[$];

  // Model predictions indexed by cycle after reset release.
  bit          e_ret[MAXC];
  bit          e_busy[MAXC];
  bit          e_exec[MAXC];
  logic [7:0]  e_in1[MAXC];
  logic [7:0]  e_in2[MAXC];
  alu_opcode_t e_op[MAXC];
  bit          e_wb[MAXC];
  logic [1:0]  e_wb_rd[MAXC];
  logic [7:0]  e_wb_val[MAXC];
  alu_flags_t  e_flags[MAXC];
  logic [7:0]  m_regs[4];
  alu_flags_t  m_flags;
  logic [7:0]  m_pc;
  int          m_halt_cyc;
  bit          m_ill;
  int          m_total;
  bit          saw_wrap;

  function automatic int get_stall(int idx);
    return (idx < stall_q.size()) ? stall_q[idx] : 1000000;
  endfunction

  // Instruction-level model: each instruction costs stall+3 cycles.
  task automatic build_model();
    int t, s, ex;
    logic [3:0] opc;
    logic [1:0] rd, rs;
    logic [7:0] imm, a, b;
    logic [11:0] res;
    bit writes;
    for (int c = 0; c < MAXC; c++) begin
      e_ret[c] = 0; e_busy[c] = 0; e_exec[c] = 0; e_wb[c] = 0;
    end
    for (int r = 0; r < 4; r++) m_regs[r] = 8'h00;
    m_flags = '0; m_pc = 8'h00; m_halt_cyc = -1; m_ill = 0; t = 0;
    for (int i = 0; i < prog.size(); i++) begin
      opc = prog[i][15:12]; rd = prog[i][11:10]; rs = prog[i][9:8]; imm = prog[i][7:0];
      s = stall_q[i];
      ex = t + s + 2;
      m_pc = m_pc + 8'd1;
      e_busy[t + s + 1] = 1;
      if (opc >= 4'hB && opc <= 4'hE) begin m_ill = 1; m_halt_cyc = ex; break; end
      if (opc == 4'hF) begin m_halt_cyc = ex; e_ret[ex] = 1; break; end
      e_busy[ex] = 1;
      writes = 0;
      if (opc == 4'h9) begin
        m_regs[rd] = imm; writes = 1;
      end else if (opc != 4'h0) begin
        a = m_regs[rd];
        b = (opc >= 4'h6 && opc <= 4'h8) ? 8'h00 : ((opc == 4'hA) ? imm : m_regs[rs]);
        res = alu_fn(op_to_alu(opc), a, b);
        e_exec[ex] = 1; e_in1[ex] = a; e_in2[ex] = b; e_op[ex] = op_to_alu(opc);
        m_regs[rd] = res[7:0]; m_flags = res[11:8]; writes = 1;
      end
      if (writes) begin
        e_wb[ex + 1] = 1; e_wb_rd[ex + 1] = rd; e_wb_val[ex + 1] = m_regs[rd];
        e_flags[ex + 1] = m_flags;
      end
      e_ret[ex + 1] = 1;
      t = ex + 1;
    end
    m_total = (m_halt_cyc >= 0) ? m_halt_cyc + 6 : t + 6;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0; dbg_sel = 2'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Runs the loaded program from reset and compares every cycle to the model.
  task automatic run_and_check(input string tag);
    int fidx, wait_left;
    bit prev_stall;
    logic [7:0] prev_addr, last_addr;
    bit exp_h;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    for (int k = 0; k < prog.size(); k++) mem[k % 256] = prog[k];
    build_model();
    do_reset();
    fidx = 0; wait_left = get_stall(0); prev_stall = 0; saw_wrap = 0;
    prev_addr = imem_addr; last_addr = imem_addr;
    for (int c = 0; c < m_total; c++) begin
      checks++;
      if (retired !== e_ret[c]) begin
        errors++; $display("FAIL %s retired cyc %0d: got %b want %b", tag, c, retired, e_ret[c]);
      end
      exp_h = (m_halt_cyc >= 0) && (c >= m_halt_cyc);
      checks++;
      if (halted !== exp_h || illegal !== (exp_h && m_ill)) begin
        errors++; $display("FAIL %s halted/illegal cyc %0d: got %b/%b want %b/%b",
                           tag, c, halted, illegal, exp_h, exp_h && m_ill);
      end
      if (exp_h || e_busy[c]) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++; $display("FAIL %s imem_req idle cyc %0d: got %b want 0", tag, c, imem_req);
        end
      end
      if (prev_stall) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++; $display("FAIL %s stall hold cyc %0d: req %b addr %h want req 1 addr %h",
                             tag, c, imem_req, imem_addr, prev_addr);
        end
      end
      checks++;
      if (e_exec[c]) begin
        if (alu_in1 !== e_in1[c] || alu_in2 !== e_in2[c] || alu_op !== e_op[c]) begin
          errors++; $display("FAIL %s alu drive cyc %0d: got %h %h %s want %h %h %s",
                             tag, c, alu_in1, alu_in2, alu_op.name(), e_in1[c], e_in2[c], e_op[c].name());
        end
      end else if (alu_op !== ALU_ADD) begin
        errors++; $display("FAIL %s alu_op idle cyc %0d: got %s want ALU_ADD", tag, c, alu_op.name());
      end
      if (e_wb[c]) begin
        dbg_sel = e_wb_rd[c];
        #1;
        checks++;
        if (dbg_rdata !== e_wb_val[c] || flags_q !== e_flags[c]) begin
          errors++; $display("FAIL %s writeback cyc %0d R%0d: got %h flags %b want %h flags %b",
                             tag, c, e_wb_rd[c], dbg_rdata, flags_q, e_wb_val[c], e_flags[c]);
        end
      end
      if (last_addr == 8'hFF && imem_addr == 8'h00) saw_wrap = 1;
      last_addr = imem_addr;
      prev_addr = imem_addr;
      if (imem_req === 1'b1) begin
        if (wait_left > 0) begin
          imem_valid = 1'b0; wait_left--; prev_stall = 1;
        end else begin
          imem_valid = 1'b1; prev_stall = 0; fidx++; wait_left = get_stall(fidx);
        end
      end else begin
        imem_valid = 1'($urandom_range(0, 1)); prev_stall = 0;
      end
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      checks++;
      if (dbg_rdata !== m_regs[r]) begin
        errors++; $display("FAIL %s final R%0d: got %h want %h", tag, r, dbg_rdata, m_regs[r]);
      end
    end
    checks++;
    if (flags_q !== m_flags || pc !== m_pc || imem_addr !== m_pc) begin
      errors++; $display("FAIL %s final flags/pc: got %b %h want %b %h", tag, flags_q, pc, m_flags, m_pc);
    end
  endtask

  task automatic test_stream();
    prog = '{ins(4'h9, 2'd0, 2'd0, 8'h7F), ins(4'h9, 2'd1, 2'd0, 8'h01), ins(4'h1, 2'd0, 2'd1, 8'h00)};
    stall_q = '{0, 0, 0};
    run_and_check("stream");
    dbg_sel = 2'd0; #1;
    checks++;
    if (dbg_rdata !== 8'h80 || pc !== 8'd3 || flags_q !== 4'b0011) begin
      errors++; $display("FAIL stream result: R0 %h pc %h flags %b want 80 03 0011", dbg_rdata, pc, flags_q);
    end
  endtask

  // Asynchronous reset from a non-trivial state, checked before any clock edge.
  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 8'h00 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00 ||
        alu_op !== ALU_ADD || flags_q !== 4'b0000 || retired !== 1'b0 ||
        halted !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset values: req %b pc %h in %h %h op %s flags %b ret %b h %b i %b want all zero/ALU_ADD",
                         imem_req, pc, alu_in1, alu_in2, alu_op.name(), flags_q, retired, halted, illegal);
    end
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      checks++;
      if (dbg_rdata !== 8'h00) begin
        errors++; $display("FAIL reset R%0d: got %h want 00", r, dbg_rdata);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL reset release req: got %b want 1", imem_req);
    end
  endtask

  task automatic test_sub_sra_addi();
    prog = '{ins(4'h9, 2'd2, 2'd0, 8'h00), ins(4'h9, 2'd3, 2'd0, 8'h01),
             ins(4'h2, 2'd2, 2'd3, 8'h00), ins(4'h8, 2'd2, 2'd1, 8'h00),
             ins(4'hA, 2'd3, 2'd0, 8'hFF)};
    stall_q = '{0, 1, 0, 2, 0};
    run_and_check("sub_sra_addi");
    dbg_sel = 2'd2; #1;
    checks++;
    if (dbg_rdata !== 8'hFF) begin errors++; $display("FAIL sub_sra R2: got %h want FF", dbg_rdata); end
    dbg_sel = 2'd3; #1;
    checks++;
    if (dbg_rdata !== 8'h00) begin errors++; $display("FAIL addi R3: got %h want 00", dbg_rdata); end
  endtask

  task automatic test_fetch_stall();
    prog = '{ins(4'h9, 2'd0, 2'd0, 8'h11), ins(4'h9, 2'd1, 2'd0, 8'h22), ins(4'h5, 2'd0, 2'd1, 8'h00)};
    stall_q = '{0, 4, 0};
    run_and_check("stall");
    dbg_sel = 2'd0; #1;
    checks++;
    if (dbg_rdata !== 8'h33) begin errors++; $display("FAIL stall R0: got %h want 33", dbg_rdata); end
  endtask

  task automatic test_illegal();
    prog = '{ins(4'h9, 2'd0, 2'd0, 8'h12), ins(4'h9, 2'd1, 2'd0, 8'h34),
             ins(4'h1, 2'd0, 2'd1, 8'h00), ins(4'hC, 2'd0, 2'd1, 8'h00)};
    stall_q = '{0, 0, 2, 0};
    run_and_check("illegal");
    dbg_sel = 2'd0; #1;
    checks++;
    if (illegal !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || dbg_rdata !== 8'h46) begin
      errors++; $display("FAIL illegal end: ill %b halt %b req %b R0 %h want 1 1 0 46",
                         illegal, halted, imem_req, dbg_rdata);
    end
  endtask

  task automatic test_halt();
    prog = '{ins(4'hF, 2'd0, 2'd0, 8'h00)};
    stall_q = '{1};
    run_and_check("halt");
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b0) begin
      errors++; $display("FAIL halt end: halt %b ill %b want 1 0", halted, illegal);
    end
  endtask

  task automatic test_reset_mid_exec();
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[0] = ins(4'h9, 2'd1, 2'd0, 8'h55);
    do_reset();
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_rdata !== 8'h00 || pc !== 8'h00) begin
      errors++; $display("FAIL reset mid-exec: R1 %h pc %h want 00 00", dbg_rdata, pc);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (dbg_rdata !== 8'h00 || pc !== 8'h00 || retired !== 1'b0) begin
      errors++; $display("FAIL reset mid-exec held: R1 %h pc %h ret %b want 00 00 0", dbg_rdata, pc, retired);
    end
    rst = 1'b0;
  endtask

  task automatic test_pc_wrap();
    prog.delete(); stall_q.delete();
    for (int k = 0; k < 257; k++) begin prog.push_back(16'h0000); stall_q.push_back(0); end
    run_and_check("pc_wrap");
    checks++;
    if (saw_wrap !== 1'b1 || pc !== 8'h01) begin
      errors++; $display("FAIL pc wrap: wrap seen %b pc %h want 1 01", saw_wrap, pc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int n;
      prog.delete(); stall_q.delete();
      n = $urandom_range(8, 14);
      for (int k = 0; k < n; k++) begin
        prog.push_back(ins(4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)),
                           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))));
        stall_q.push_back($urandom_range(0, 3));
      end
      if (it == 2) begin prog.push_back(16'hF000); stall_q.push_back(0); end
      if (it == 3) begin prog.push_back(ins(4'($urandom_range(11, 14)), 2'd0, 2'd0, 8'h00)); stall_q.push_back(1); end
      run_and_check($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b0; dbg_sel = 2'd0;
    repeat (3) @(posedge clk);
    test_stream();
    test_reset();
    test_sub_sra_addi();
    test_fetch_stall();
    test_illegal();
    test_halt();
    test_reset_mid_exec();
    test_pc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle fetch/decode/execute controller for the 8-bit CPU, sitting directly upstream of `alu`. It fetches 16-bit instructions over a request/valid handshake and holds a 4-entry register file and a flags register. It drives the ALU's `in1`/`in2`/`alu_op` (type `alu_opcode_t` from `defs_pkg`), then writes the ALU `out` and `flags` (type `alu_flags_t`) back.

## Interface
- `WIDTH`, 8: datapath width; must match `alu` `WIDTH`.
- `PC_W`, 8: program counter / instruction address width.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out `PC_W`: fetch address, equal to `pc`.
- `imem_valid` in 1: instruction available this cycle.
- `imem_data` in 16: instruction word.
- `alu_in1` out `WIDTH`: ALU operand 1.
- `alu_in2` out `WIDTH`: ALU operand 2.
- `alu_op` out `alu_opcode_t`: ALU operation.
- `alu_out` in `WIDTH`: ALU result.
- `alu_flags` in `alu_flags_t`: ALU flags.
- `flags_q` out `alu_flags_t`: architectural flags register.
- `pc` out `PC_W`: current program counter.
- `retired` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: core stopped (HALT or illegal).
- `illegal` out 1: sticky; set when an illegal opcode is decoded.
- `dbg_sel` in 2: register-file debug read select.
- `dbg_rdata` out `WIDTH`: combinational `R[dbg_sel]`.

## Operation
- Instruction fields: `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs, `[7:0]` imm. The imm is zero-extended or truncated to `WIDTH`.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR (rd ← rd op rs)
  - 6 SLL, 7 SRL, 8 SRA (rd ← shift of rd by one; `alu_in2` = 0)
  - 9 LI (rd ← imm)
  - A ADDI (rd ← rd + imm)
  - F HALT
  - B–E are illegal.
- For ALU ops and ADDI: `alu_in1` = R[rd]; `alu_in2` = R[rs], or imm for ADDI; `alu_op` = the matching `ALU_*`.
- Write rules:
  - Only ALU ops and ADDI write `flags_q`.
  - LI writes rd and leaves `flags_q` unchanged.
  - NOP writes nothing.
- FSM states: FETCH, DECODE, EXEC, HALT.
  - FETCH: `imem_req`=1. When `imem_valid`=1, latch `imem_data` into IR, set `pc` ← `pc`+1 (mod 2^`PC_W`), go to DECODE.
  - DECODE:
    - Illegal opcode: set `illegal`, go to HALT, no retire.
    - HALT: go to HALT and pulse `retired`.
    - Otherwise: latch operands into the operand registers, go to EXEC.
  - EXEC: ALU inputs are driven from the operand registers. At the cycle end, write back per opcode, pulse `retired`, go to FETCH.
  - HALT: terminal; `imem_req`=0; only `rst` exits.
- `retired` is registered and asserts in the cycle after the retiring state.
- When not in EXEC: `alu_in1`/`alu_in2` hold their last values, and `alu_op` = `ALU_ADD`.

## Timing
- Reset values, applied asynchronously:
  - state=FETCH, `pc`=0, R0–R3=0, IR=0, `flags_q`=0.
  - `alu_in1`=0, `alu_in2`=0, `alu_op`=`ALU_ADD`.
  - `retired`=0, `halted`=0, `illegal`=0.
  - `imem_req` is deasserted during reset and asserts in the first cycle after release.
- Instruction latency is 3 cycles (FETCH, DECODE, EXEC) when `imem_valid` is high in the first FETCH cycle. Each cycle of `imem_valid`=0 adds one cycle.
- Handshake:
  - `imem_req` and `imem_addr` hold stable until `imem_valid`.
  - `imem_valid` outside FETCH is ignored.
  - No new request is issued before DECODE completes.
- Boundary conditions:
  - rd==rs reads the pre-write value.
  - `pc` wraps from 2^`PC_W`−1 to 0.
  - Writeback to the register that `dbg_sel` selects appears on `dbg_rdata` the following cycle.
- Reset asserted mid-FETCH/EXEC: immediate return to reset values; a pending writeback is discarded.
- `halted` = (state==HALT), registered. It asserts the cycle after DECODE of HALT or an illegal opcode.

## Test plan
- Reset then stream:
  - Stimulus: LI R0,0x7F; LI R1,0x01; ADD R0,R1; `imem_valid` held high.
  - Required: R0=0x80, `flags_q` = ALU flags for 0x7F+0x01; `retired` pulses at cycles 3, 6, 9; `pc`=3.
- SUB, SRA, ADDI wrap:
  - Stimulus: LI R2,0x00; LI R3,0x01; SUB R2,R3; SRA R2; ADDI R3,0xFF.
  - Required: R2=0xFF, R3=0x00, `alu_in2`=0 during the SRA EXEC.
- Fetch stall:
  - Stimulus: `imem_valid` low for 4 cycles on the second fetch.
  - Required: `imem_addr`=1 is stable throughout, no extra `retired` pulses, and that instruction retires 4 cycles later.
- Illegal and HALT:
  - Stimulus: opcode 0xC.
  - Required: `illegal`=1, `halted`=1, no register or flags change, `imem_req`=0 thereafter.
  - HALT alone gives `halted`=1 with `illegal`=0.
- Reset mid-EXEC:
  - Stimulus: assert `rst` during the EXEC of LI R1,0x55.
  - Required: R1 stays 0 and `pc`=0.
- PC wrap:
  - Stimulus: NOP stream past address 255.
  - Required: `imem_addr` goes 0xFF→0x00.
